alloc_issue_inoq: RTL and testbench

- Next-generation in-order reservation-station allocate/issue controller.
- Replaces busy-vector search with explicit head/tail pointers and an occupancy counter.
- Supports up to DISPW allocations per cycle, selective mispredict kill via per-entry kill vector, and an exported busy vector.
- Sits between the dispatch (DP) stage and one in-order execution unit; the RS payload RAM is indexed by allocptr/issueptr.

---
 rtl/alloc_issue_inoq.sv | 123 ++++++++++++
 tb/tb_alloc_issue_inoq.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/alloc_issue_inoq.sv
// In-order reservation-station allocate/issue control: head/tail ring pointers, occupancy count, busy flags.
// Build option RS_ALLOC_EARLY_FREE_EN lets a slot freed by this cycle's issue be reallocated in the same cycle.
module alloc_issue_inoq #(
  parameter int ENTSEL = 2,
  parameter int ENTNUM = 4,
  parameter int DISPW  = 2,
  parameter int REQW   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REQW-1:0]   reqnum,
  input  logic [ENTNUM-1:0] readyvec,
  input  logic              prmiss,
  input  logic [ENTNUM-1:0] prkillvec,
  input  logic              exunit_busynext,
  input  logic              stall_DP,
  input  logic              kill_DP,
  output logic [ENTSEL-1:0] allocptr,
  output logic              allocatable,
  output logic [ENTSEL-1:0] issueptr,
  output logic              issuevalid,
  output logic [ENTNUM-1:0] busyvec,
  output logic [ENTSEL:0]   count
);

  localparam int CW  = ENTSEL + 2;
  localparam int PW1 = ENTSEL + 1;

  if (ENTNUM != (1 << ENTSEL) || ENTNUM < 2) begin : g_bad_entnum
    $error("alloc_issue_inoq: ENTNUM must equal 2**ENTSEL and be at least 2");
  end
  if (DISPW < 1 || DISPW > ENTNUM || DISPW >= (1 << REQW)) begin : g_bad_dispw
    $error("alloc_issue_inoq: DISPW out of range or does not fit in REQW");
  end

  logic [ENTSEL-1:0] head;
  logic [ENTSEL-1:0] tail;
  logic [ENTSEL:0]   cnt;
  logic [ENTNUM-1:0] busy;

  logic [CW-1:0]     req_w;
  logic [CW-1:0]     cnt_w;
  logic [CW-1:0]     fit_sum;
  logic              alloc_fire;
  logic [ENTNUM-1:0] alloc_mask;
  logic [ENTNUM-1:0] issue_mask;
  logic [ENTNUM-1:0] kept;
  logic [ENTSEL:0]   kept_cnt;
  logic [ENTSEL:0]   cnt_next;

  function automatic logic [ENTSEL-1:0] ring_off(input logic [ENTSEL-1:0] idx,
                                                 input logic [ENTSEL-1:0] base);
    return idx - base;
  endfunction

  assign req_w = CW'(reqnum);
  assign cnt_w = CW'(cnt);

  assign issuevalid = busy[head] & readyvec[head] & ~prmiss & ~exunit_busynext;

`ifdef RS_ALLOC_EARLY_FREE_EN
  // Issue is never active when the head is empty, so count - issuevalid cannot underflow.
  assign fit_sum = cnt_w - CW'(issuevalid) + req_w;
`else
  assign fit_sum = cnt_w + req_w;
`endif

  assign allocatable = (fit_sum <= CW'(ENTNUM));
  assign alloc_fire  = ~reset & ~prmiss & ~stall_DP & ~kill_DP & allocatable & (reqnum != '0);

  // Entries tail .. tail+reqnum-1 (mod ENTNUM) are claimed by this cycle's allocation.
  always_comb begin
    alloc_mask = '0;
    issue_mask = '0;
    for (int j = 0; j < ENTNUM; j++) begin
      if (alloc_fire && (CW'(ring_off(ENTSEL'(j), tail)) < req_w)) begin
        alloc_mask[j] = 1'b1;
      end
      if (issuevalid && (ENTSEL'(j) == head)) begin
        issue_mask[j] = 1'b1;
      end
    end
  end

  always_comb begin
    kept     = busy & ~prkillvec;
    kept_cnt = '0;
    for (int j = 0; j < ENTNUM; j++) begin
      kept_cnt = kept_cnt + PW1'(kept[j]);
    end
  end

  assign cnt_next = cnt + (alloc_fire ? PW1'(reqnum) : '0) - PW1'(issuevalid);

  always_ff @(posedge clk) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
      busy <= '0;
    end else if (prmiss) begin
      busy <= kept;
      cnt  <= kept_cnt;
      tail <= head + ENTSEL'(kept_cnt);
    end else begin
      // Allocation is applied after the issue clear so a reused slot stays busy.
      busy <= (busy & ~issue_mask) | alloc_mask;
      cnt  <= cnt_next;
      if (alloc_fire) begin
        tail <= tail + ENTSEL'(reqnum);
      end
      if (issuevalid) begin
        head <= head + ENTSEL'(1);
      end
    end
  end

  assign allocptr = tail;
  assign issueptr = head;
  assign busyvec  = busy;
  assign count    = cnt;

endmodule

// File: tb/tb_alloc_issue_inoq.sv
// Bench for alloc_issue_inoq: directed scenarios then random traffic against a queue-based occupancy model.
module tb_alloc_issue_inoq;
  localparam int ENTSEL = 2;
  localparam int ENTNUM = 4;
  localparam int DISPW  = 2;
  localparam int REQW   = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [REQW-1:0]   reqnum;
  logic [ENTNUM-1:0] readyvec;
  logic              prmiss;
  logic [ENTNUM-1:0] prkillvec;
  logic              exunit_busynext;
  logic              stall_DP;
  logic              kill_DP;
  logic [ENTSEL-1:0] allocptr;
  logic              allocatable;
  logic [ENTSEL-1:0] issueptr;
  logic              issuevalid;
  logic [ENTNUM-1:0] busyvec;
  logic [ENTSEL:0]   count;

  always #5 clk = ~clk;

  alloc_issue_inoq #(.ENTSEL(ENTSEL), .ENTNUM(ENTNUM), .DISPW(DISPW), .REQW(REQW)) dut (
    .clk(clk), .reset(reset), .reqnum(reqnum), .readyvec(readyvec), .prmiss(prmiss),
    .prkillvec(prkillvec), .exunit_busynext(exunit_busynext), .stall_DP(stall_DP),
    .kill_DP(kill_DP), .allocptr(allocptr), .allocatable(allocatable), .issueptr(issueptr),
    .issuevalid(issuevalid), .busyvec(busyvec), .count(count)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: occupied entry indices oldest-first, plus the head index.
  int q[$];
  int m_head = 0;
  logic al_seen;
  logic iv_seen;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_tail();
    return (m_head + q.size()) % ENTNUM;
  endfunction

  function automatic logic [ENTNUM-1:0] m_busy();
    logic [ENTNUM-1:0] b = '0;
    foreach (q[k]) b[q[k]] = 1'b1;
    return b;
  endfunction

  function automatic bit kill_ok(input logic [ENTNUM-1:0] kv);
    bit in_suffix = 1'b1;
    for (int j = q.size() - 1; j >= 0; j--) begin
      if (kv[q[j]]) begin
        if (!in_suffix) return 1'b0;
      end else begin
        in_suffix = 1'b0;
      end
    end
    return (kv & ~m_busy()) == '0;
  endfunction

  task automatic step(input int rn, input logic [ENTNUM-1:0] rdy, input logic pm,
                      input logic [ENTNUM-1:0] kv, input logic exb, input logic st,
                      input logic kl, input logic rs);
    bit exp_iv;
    bit exp_al;
    bit fire;
    int t;
    int occ_after_issue;
    reset = rs; reqnum = REQW'(rn); readyvec = rdy; prmiss = pm; prkillvec = kv;
    exunit_busynext = exb; stall_DP = st; kill_DP = kl;
    #1;
    exp_iv = (q.size() > 0) && rdy[q[0]] && !pm && !exb;
`ifdef RS_ALLOC_EARLY_FREE_EN
    occ_after_issue = q.size() - (exp_iv ? 1 : 0);
`else
    occ_after_issue = q.size();
`endif
    exp_al = (occ_after_issue + rn) <= ENTNUM;
    chk_eq("allocptr", allocptr, m_tail());
    chk_eq("issueptr", issueptr, m_head);
    chk_eq("count", count, q.size());
    chk_eq("busyvec", busyvec, m_busy());
    chk_eq("allocatable", allocatable, exp_al);
    chk_eq("issuevalid", issuevalid, exp_iv);
    al_seen = allocatable;
    iv_seen = issuevalid;
    if (pm && !rs) begin
      assert (kill_ok(kv)) else $error("prkillvec %b is not a youngest suffix of %b", kv, m_busy());
    end
    if (rs) begin
      q.delete();
      m_head = 0;
    end else if (pm) begin
      while (q.size() > 0 && kv[q[q.size()-1]]) void'(q.pop_back());
    end else begin
      fire = !st && !kl && exp_al && (rn != 0);
      t = m_tail();
      if (exp_iv) begin
        void'(q.pop_front());
        m_head = (m_head + 1) % ENTNUM;
      end
      if (fire) for (int i = 0; i < rn; i++) q.push_back((t + i) % ENTNUM);
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; reqnum = '0; readyvec = '0; prmiss = 1'b0; prkillvec = '0;
    exunit_busynext = 1'b0; stall_DP = 1'b0; kill_DP = 1'b0;
    @(negedge clk);
    step(0, '0, 0, '0, 0, 0, 0, 1);

    // Fill with two 2-wide allocations, then a refused request.
    step(2, '0, 0, '0, 0, 0, 0, 0);
    step(2, '0, 0, '0, 0, 0, 0, 0);
    chk_eq("fill_allocptr", allocptr, 0);
    chk_eq("fill_count", count, 4);
    chk_eq("fill_busyvec", busyvec, 4'b1111);
    step(1, '0, 0, '0, 0, 0, 0, 0);
    chk_eq("full_allocatable", al_seen, 0);
    chk_eq("full_count_hold", count, 4);

    // Drain in order.
    for (int i = 0; i < 4; i++) begin
      chk_eq("drain_issueptr", issueptr, i);
      step(0, 4'b1111, 0, '0, 0, 0, 0, 0);
    end
    chk_eq("drain_count", count, 0);
    step(0, 4'b1111, 0, '0, 0, 0, 0, 0);
    chk_eq("empty_issuevalid", iv_seen, 0);

    // Move head to 3, then a wrapping allocation.
    step(2, '0, 0, '0, 0, 0, 0, 0);
    step(1, '0, 0, '0, 0, 0, 0, 0);
    repeat (3) step(0, 4'b1111, 0, '0, 0, 0, 0, 0);
    chk_eq("pre_wrap_head", issueptr, 3);
    step(2, '0, 0, '0, 0, 0, 0, 0);
    chk_eq("wrap_busyvec", busyvec, 4'b1001);
    chk_eq("wrap_allocptr", allocptr, 1);
    chk_eq("wrap_count", count, 2);

    // Entries 1..3 occupied, kill the two youngest.
    repeat (2) step(0, 4'b1111, 0, '0, 0, 0, 0, 0);
    step(2, '0, 0, '0, 0, 0, 0, 0);
    step(1, '0, 0, '0, 0, 0, 0, 0);
    step(0, 4'b0010, 1, 4'b1100, 0, 0, 0, 0);
    chk_eq("kill_issuevalid", iv_seen, 0);
    chk_eq("kill_busyvec", busyvec, 4'b0010);
    chk_eq("kill_count", count, 1);
    chk_eq("kill_allocptr", allocptr, 2);

    // count=3 with ready head and reqnum=2.
    step(2, '0, 0, '0, 0, 0, 0, 0);
    chk_eq("ef_pre_count", count, 3);
    step(2, 4'b1111, 0, '0, 0, 0, 0, 0);
`ifdef RS_ALLOC_EARLY_FREE_EN
    chk_eq("ef_allocatable", al_seen, 1);
    chk_eq("ef_count", count, 4);
`else
    chk_eq("ef_allocatable", al_seen, 0);
    chk_eq("ef_count", count, 2);
`endif

    // Reset wins over concurrent allocation request and prmiss.
    step(2, 4'b1111, 1, '0, 0, 0, 0, 1);
    chk_eq("rst_allocptr", allocptr, 0);
    chk_eq("rst_issueptr", issueptr, 0);
    chk_eq("rst_count", count, 0);
    chk_eq("rst_busyvec", busyvec, 0);

    for (int c = 0; c < 3000; c++) begin
      logic [ENTNUM-1:0] kv;
      logic pm;
      int k;
      kv = '0;
      pm = ($urandom_range(0, 9) == 0);
      if (pm) begin
        k = $urandom_range(0, q.size());
        for (int j = 0; j < k; j++) kv[q[q.size()-1-j]] = 1'b1;
      end
      step($urandom_range(0, DISPW), ENTNUM'($urandom), pm, kv,
           $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 11) == 0, $urandom_range(0, 199) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
